// File: rtl/uart_fifo_if.sv
// UART FIFO bundle: TX/RX word handshakes, serial lines and status pulses.
// master = user/line side, slave = uart_fifo.
interface uart_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 uart_txd;
    logic                 uart_rxd;
    logic                 tx_busy;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_parity_err;

    modport master (
        output tx_data, tx_valid, rx_ready, uart_rxd,
        input  tx_ready, rx_data, rx_valid, uart_txd,
        input  tx_busy, rx_frame_err, rx_overrun, rx_parity_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, uart_rxd,
        output tx_ready, rx_data, rx_valid, uart_txd,
        output tx_busy, rx_frame_err, rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/uart_fifo.sv
// UART with TX and RX word FIFOs, 8N1-style framing, LSB first.
// Define UART_FIFO_PARITY_EN to add one even-parity bit per frame.
module uart_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic        clk,
    input logic        rst_n,
    uart_fifo_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(DIV / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
`ifdef UART_FIFO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_e;

    typedef logic [DATA_BITS-1:0] word_t;

    // ---------------- TX FIFO ----------------
    word_t         tx_mem_q [FIFO_DEPTH];
    word_t         tx_mem_d [FIFO_DEPTH];
    logic [AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic          tx_empty, tx_full, tx_push, tx_pop;
    word_t         tx_head;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                      (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign tx_push  = bus.tx_valid && !tx_full;
    assign tx_head  = tx_mem_q[tx_rd_q[AW-1:0]];

    // TX FIFO pointer and storage update
    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        if (tx_push) begin
            tx_mem_d[tx_wr_q[AW-1:0]] = bus.tx_data;
            tx_wr_d = tx_wr_q + PTR_ONE;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + PTR_ONE;
    end

    // ---------------- TX FSM ----------------
    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]   tx_bit_q, tx_bit_d;
    word_t           tx_shift_q, tx_shift_d;
    logic            tx_par_q, tx_par_d;
    logic            txd_q, txd_d;
    logic            tx_cnt_end;

    assign tx_cnt_end = (tx_cnt_q == DIV_M1);

    // TX framing: pop a word, then start/data/parity/stop, DIV clocks each
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = START;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_head;
                    tx_par_d   = ^tx_head;
                    txd_d      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_end) begin
                    tx_state_d = DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (tx_cnt_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = PAR_EN ? PARITY : STOP;
                        txd_d      = PAR_EN ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + BW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (tx_cnt_end) begin
                    tx_state_d = STOP;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (tx_cnt_end) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = START;
                        tx_shift_d = tx_head;
                        tx_par_d   = ^tx_head;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = IDLE;
                        txd_d      = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    word_t         rx_mem_q [FIFO_DEPTH];
    word_t         rx_mem_d [FIFO_DEPTH];
    logic [AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic          rx_empty, rx_full, rx_push, rx_pop;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                      (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign rx_pop   = bus.rx_ready && !rx_empty;

    // ---------------- RX synchroniser + FSM ----------------
    logic            rxd_s1_q, rxd_s2_q, rxd_prev_q;
    logic            rxd, rx_fall;
    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]   rx_bit_q, rx_bit_d;
    word_t           rx_shift_q, rx_shift_d;
    logic            rx_armed_q, rx_armed_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            rx_ovr_q, rx_ovr_d;
    logic            rx_perr_q, rx_perr_d;
    logic            rx_cnt_end;

    assign rxd        = rxd_s2_q;
    assign rx_fall    = rxd_prev_q && !rxd_s2_q;
    assign rx_cnt_end = (rx_cnt_q == DIV_M1);

    // RX FIFO pointer and storage update; a full FIFO accepts a push
    // in the same cycle it is popped
    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_q[AW-1:0]] = rx_shift_q;
            rx_wr_d = rx_wr_q + PTR_ONE;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + PTR_ONE;
    end

    // RX framing: arm on a full idle bit, mid-bit sampling, stop checks
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_armed_d = rx_armed_q;
        rx_ferr_d  = 1'b0;
        rx_ovr_d   = 1'b0;
        rx_perr_d  = 1'b0;
        rx_push    = 1'b0;
        unique case (rx_state_q)
            IDLE: begin
                if (!rx_armed_q) begin
                    if (!rxd) begin
                        rx_cnt_d = '0;
                    end else if (rx_cnt_end) begin
                        rx_armed_d = 1'b1;
                        rx_cnt_d   = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end else if (rx_fall) begin
                    rx_state_d = START;
                    rx_cnt_d   = '0;
                end
            end
            START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd ? IDLE : DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = PAR_EN ? PARITY : STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = (rxd != ^rx_shift_q);
                    rx_state_d = STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (rx_cnt_end) begin
                    rx_cnt_d   = '0;
                    rx_state_d = IDLE;
                    if (!rxd) begin
                        rx_ferr_d = 1'b1;
                    end else if (!rx_full || rx_pop) begin
                        rx_push = 1'b1;
                    end else begin
                        rx_ovr_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    // State registers for both directions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_armed_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
            rxd_s1_q   <= bus.uart_rxd;
            rxd_s2_q   <= rxd_s1_q;
            rxd_prev_q <= rxd_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_armed_q <= rx_armed_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    assign bus.tx_ready      = !tx_full;
    assign bus.tx_busy       = (tx_state_q != IDLE) || !tx_empty;
    assign bus.uart_txd      = txd_q;
    assign bus.rx_valid      = !rx_empty;
    assign bus.rx_data       = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_overrun    = rx_ovr_q;
    assign bus.rx_parity_err = PAR_EN ? rx_perr_q : 1'b0;

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: line timing, loopback, errors, reset.
// Expected RX contents come from a word queue fed by what the bench sends.
module tb_uart_fifo;
    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 115200;
    localparam int DB     = 8;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_FIFO_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = DB + 3;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = DB + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loop_en = 1'b1;
    logic rxd_drv = 1'b1;
    always #10 clk = ~clk;

    uart_fifo_if #(.DATA_BITS(DB)) bus ();
    assign bus.uart_rxd = loop_en ? bus.uart_txd : rxd_drv;

    uart_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD),
        .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int ferr_n = 0, ovr_n = 0, perr_n = 0;
    int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    logic [DB-1:0] rxq[$];

    // pulse counters; a one-cycle pulse adds exactly one
    always @(negedge clk) begin
        ferr_n <= ferr_n + int'(bus.rx_frame_err);
        ovr_n  <= ovr_n + int'(bus.rx_overrun);
        perr_n <= perr_n + int'(bus.rx_parity_err);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [DB-1:0] w,
                                                 input logic stop,
                                                 input logic pflip);
        logic [NB-1:0] b;
        b = '0;
        for (int i = 0; i < DB; i++) b[i+1] = w[i];
        if (PAR) b[DB+1] = (^w) ^ pflip;
        b[NB-1] = stop;
        return b;
    endfunction

    // reference: a word reaching the receiver is queued unless 4 are held
    function automatic void model_rx(input logic [DB-1:0] w);
        if (rxq.size() < DEPTH) rxq.push_back(w);
        else exp_ovr++;
    endfunction

    task automatic send(input logic [DB-1:0] w);
        bit ok;
        ok = 0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        for (int i = 0; i < 6 * NB * DIV; i++) begin
            if (bus.tx_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("send_accepted", 32'(ok), 1);
        if (ok && loop_en) model_rx(w);
    endtask

    task automatic wait_start();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3 * NB * DIV; i++) begin
            if (bus.uart_txd === 1'b0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("tx_start_seen", 32'(ok), 1);
    endtask

    // checks first and last clock of every bit, ends at next frame start
    task automatic frame_check(input logic [DB-1:0] w);
        logic [NB-1:0] b;
        b = frame_bits(w, 1'b1, 1'b0);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("txd_%02h_b%0d_first", w, k), 32'(bus.uart_txd),
                  32'(b[k]));
            repeat (DIV - 1) @(negedge clk);
            check($sformatf("txd_%02h_b%0d_last", w, k), 32'(bus.uart_txd),
                  32'(b[k]));
            if (k == NB - 1) check("busy_in_stop", 32'(bus.tx_busy), 1);
            @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [DB-1:0] w, input logic stop,
                               input logic pflip);
        logic [NB-1:0] b;
        b = frame_bits(w, stop, pflip);
        for (int k = 0; k < NB; k++) begin
            rxd_drv = b[k];
            repeat (DIV) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    task automatic pop_model();
        logic [DB-1:0] e;
        e = rxq.pop_front();
        check("pop_valid", 32'(bus.rx_valid), 1);
        check($sformatf("pop_data_%02h", e), 32'(bus.rx_data), 32'(e));
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ferr"}, 32'(ferr_n), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(ovr_n), 32'(exp_ovr));
        check({tag, "_perr"}, 32'(perr_n), 32'(exp_perr));
    endtask

    initial begin
        logic [DB-1:0] w5[5];
        logic [DB-1:0] rw;
        int glen;
        w5[0] = 8'h00; w5[1] = 8'hFF; w5[2] = 8'h3C;
        w5[3] = 8'h81; w5[4] = 8'h7E;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.rx_ready = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(bus.uart_txd), 1);
        check("rst_tx_ready", 32'(bus.tx_ready), 1);
        check("rst_tx_busy", 32'(bus.tx_busy), 0);
        check("rst_rx_valid", 32'(bus.rx_valid), 0);
        check("rst_rx_data", 32'(bus.rx_data), 0);
        check("rst_pulses", {29'd0, bus.rx_frame_err, bus.rx_overrun,
                             bus.rx_parity_err}, 0);
        rst_n = 1'b1;
        repeat (DIV + 10) @(negedge clk);

        // single 0xA5 frame, looped back
        send(8'hA5);
        wait_start();
        frame_check(8'hA5);
        check("a5_busy_after", 32'(bus.tx_busy), 0);
        check("a5_txd_idle", 32'(bus.uart_txd), 1);
        pop_model();
        check("a5_rx_empty", 32'(bus.rx_valid), 0);

        // five back-to-back frames, RX not popped: last one overruns
        fork
            begin
                for (int i = 0; i < 5; i++) send(w5[i]);
                check("tx_ready_full", 32'(bus.tx_ready), 0);
            end
            begin
                wait_start();
                for (int i = 0; i < 5; i++) frame_check(w5[i]);
            end
        join
        check("b2b_busy_after", 32'(bus.tx_busy), 0);
        repeat (4) @(negedge clk);
        check_flags("b2b");
        while (rxq.size() > 0) pop_model();
        check("b2b_rx_empty", 32'(bus.rx_valid), 0);

        // random words with random pop points
        for (int n = 0; n < 4; n++) begin
            rw = DB'($urandom_range(0, (1 << DB) - 1));
            send(rw);
            wait_start();
            frame_check(rw);
            repeat (3) @(negedge clk);
            if ($urandom_range(0, 1) == 1) pop_model();
        end
        check_flags("rand");
        while (rxq.size() > 0) pop_model();
        check("rand_rx_empty", 32'(bus.rx_valid), 0);

        // glitches shorter than half a bit are dropped
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        repeat (10) @(negedge clk);
        glen = $urandom_range(20, 150);
        rxd_drv = 1'b0;
        repeat (glen) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (DIV) @(negedge clk);
        rxd_drv = 1'b0;
        repeat (200) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (DIV) @(negedge clk);
        check("glitch_rx_valid", 32'(bus.rx_valid), 0);
        check_flags("glitch");

        // stop bit low
        drive_frame(8'h55, 1'b0, 1'b0);
        exp_ferr++;
        repeat (DIV) @(negedge clk);
        check("ferr_rx_valid", 32'(bus.rx_valid), 0);
        check_flags("ferr");

        // reset in the middle of frames in both directions
        loop_en = 1'b1;
        repeat (10) @(negedge clk);
        send(8'hC3);
        wait_start();
        frame_check(8'hC3);
        send(8'h99);
        send(8'h66);
        repeat (3 * DIV) @(negedge clk);
        check("pre_rst_rx_valid", 32'(bus.rx_valid), 1);
        check("pre_rst_busy", 32'(bus.tx_busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", 32'(bus.uart_txd), 1);
        check("mid_rst_rx_valid", 32'(bus.rx_valid), 0);
        check("mid_rst_rx_data", 32'(bus.rx_data), 0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready), 1);
        check("mid_rst_busy", 32'(bus.tx_busy), 0);
        rxq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // line not yet idle for a bit: this frame must be ignored
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        repeat (DIV / 4) @(negedge clk);
        drive_frame(8'h00, 1'b1, 1'b0);
        repeat (DIV + 10) @(negedge clk);
        check("arm_rx_valid", 32'(bus.rx_valid), 0);
        check_flags("arm");

        // clean 0x12 after the abort
        loop_en = 1'b1;
        send(8'h12);
        wait_start();
        frame_check(8'h12);
        repeat (3) @(negedge clk);
        check("post_rst_count", 32'(rxq.size()), 1);
        pop_model();
        check("post_rst_rx_empty", 32'(bus.rx_valid), 0);

        if (PAR) begin
            loop_en = 1'b0;
            drive_frame(8'h12, 1'b1, 1'b1);
            exp_perr++;
            rxq.push_back(8'h12);
            repeat (DIV) @(negedge clk);
            pop_model();
        end
        repeat (4) @(negedge clk);
        check_flags("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, line rate; DIV = CLK_HZ/BAUD (integer, truncated), DIV >= 16.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal 5..9, LSB first on the line.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 16, power of two >= 2, applied to TX and RX FIFOs separately.
REQ-005 CLK  input  1  single clock; all logic on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 TX_DATA  input  DATA_BITS  word to transmit.
REQ-008 TX_VALID  input  1  TX_DATA offered; accepted when TX_VALID and TX_READY are high on the same edge.
REQ-009 TX_READY  output  1  TX FIFO not full.
REQ-010 RX_DATA  output  DATA_BITS  head of RX FIFO; valid only while RX_VALID is high.
REQ-011 RX_VALID  output  1  RX FIFO not empty.
REQ-012 RX_READY  input  1  pops RX FIFO when RX_VALID and RX_READY are high on the same edge.
REQ-013 UART_TXD  output  1  serial transmit line, idle high.
REQ-014 UART_RXD  input  1  serial receive line, asynchronous to CLK.
REQ-015 TX_BUSY  output  1  high while a frame is on the line or the TX FIFO is non-empty.
REQ-016 RX_FRAME_ERR  output  1  one-cycle pulse when a stop bit samples low.
REQ-017 RX_OVERRUN  output  1  one-cycle pulse when a received word is dropped because the RX FIFO is full.
REQ-018 RX_PARITY_ERR  output  1  one-cycle pulse on parity mismatch (see Configuration).

Function
REQ-019 The TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, each bit held for exactly DIV clocks.
REQ-020 In IDLE with the TX FIFO non-empty, the FSM SHALL pop one word and drive the start bit (0) on the next edge.
REQ-021 After STOP (1 bit, high), the FSM SHALL enter START directly when the FIFO is non-empty, giving back-to-back frames with no idle gap.
REQ-022 UART_RXD SHALL pass through a 2-flop synchroniser before any use; all RX latencies count from the synchroniser output.
REQ-023 The RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE enters START.
REQ-024 In START the line SHALL be resampled at DIV/2; if high, the event is a glitch and the FSM returns to IDLE with no push and no flags.
REQ-025 Data, parity and stop bits SHALL be sampled DIV clocks after the previous sample, i.e. at mid-bit.
REQ-026 At the stop sample: stop high -> push the word if not full, else pulse RX_OVERRUN; stop low -> pulse RX_FRAME_ERR, no push; the FSM returns to IDLE either way.
REQ-027 A word pushed at the stop sample SHALL appear as RX_VALID=1 on the following clock.
REQ-028 Each FIFO SHALL be a circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full and empty are decoded from pointer MSB/LSBs, and wrap-around is silent.
REQ-029 A simultaneous push and pop on a full or empty FIFO SHALL both succeed (full: pop then push; empty: the push shows on the next cycle).
REQ-030 A write with TX_VALID=1 while TX_READY=0 SHALL be ignored, with no state change.
REQ-031 For DATA_BITS=9, all nine bits SHALL be carried end to end unchanged.

Reset
REQ-032 Asserting RST_N low SHALL immediately and asynchronously force: UART_TXD=1, TX_READY=1, TX_BUSY=0, RX_VALID=0, RX_DATA=0, all error pulses 0, both FIFOs empty, both FSMs IDLE, all counters 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame; the partial TX word is lost and the partial RX word is never pushed.
REQ-034 After reset release, the RX FSM SHALL ignore the line until the synchroniser output has been high for one full bit period (DIV clocks).

Configuration
REQ-035 With macro UART_FIFO_PARITY_EN defined, frames SHALL carry one even-parity bit between the data and stop bits, and a mismatch SHALL pulse RX_PARITY_ERR at the parity sample; the word SHALL still be pushed.
REQ-036 Without UART_FIFO_PARITY_EN, the PARITY states SHALL be skipped and RX_PARITY_ERR SHALL be tied 0.

Verification (CLK_HZ=50000000, BAUD=115200 -> DIV=434, DATA_BITS=8, FIFO_DEPTH=4)
REQ-037 Write 0xA5 after reset -> UART_TXD shows 0,1,0,1,0,0,1,0,1,1, each bit 434 clocks wide; TX_BUSY drops after the stop bit.
REQ-038 Write 5 words back-to-back with no pops -> TX_READY=0 after 4 words are queued; all 5 frames are sent with no idle gaps between them.
REQ-039 Loop TXD to RXD, send 0x00, 0xFF, 0x3C with RX_READY=0, then send 0x81 and 0x7E -> RX_OVERRUN pulses once, on 0x7E; pops return 0x00, 0xFF, 0x3C, 0x81.
REQ-040 Drive RXD low for 200 clocks, then high -> no push, no flags.
REQ-041 Drive a frame of 0x55 with stop bit 0 -> RX_FRAME_ERR pulses once, RX_VALID stays 0.
REQ-042 Assert RST_N low mid-frame in both directions -> UART_TXD=1 and RX_VALID=0 in the same cycle; after release, the next 0x12 frame is received correctly (with parity: an injected bad-parity 0x12 pulses RX_PARITY_ERR).
